sr04_echo_responder: RTL and testbench
======================================

Name: sr04_echo_responder

Overview:
- Synthesizable model of the SR04 sensor side of the trigger/echo protocol: accepts a trigger pulse, waits for the burst delay, then drives an echo pulse whose width encodes a programmed distance at 58 us/cm.
- Drives the echo input of the distance calculator in simulation and on-board loopback.
- Allows range measurement to be checked without the physical sensor.
- Uses the same 1 us tick (i_tick) as the measurement path.

Parameters:
- TRIG_MIN_US, 10, minimum trigger high width in ticks for a trigger to be accepted.
- BURST_DELAY_US, 200, ticks from accepted trigger fall to echo rise (8 x 40 kHz burst).
- US_PER_CM, 58, echo ticks per cm.
- MAX_CM, 400, largest valid distance; zero or larger values produce a timeout echo.
- TIMEOUT_US, 38000, echo width in ticks for no-object / out-of-range.
- HOLDOFF_US, 1000, ticks after echo fall during which triggers are ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_tick  in  1  1 us strobe, one clk wide.
- trig  in  1  trigger from controller; asynchronous to clk.
- i_distance  in  10  target distance in cm; latched when a trigger is accepted.
- echo  out  1  echo pulse to receiver.
- busy  out  1  high in every state except IDLE.
- trig_err  out  1  one-cycle pulse when a trigger is rejected as too short.

Behaviour:
- Reset (rst=0, async) forces:
  - echo=0, busy=0, trig_err=0, state IDLE.
  - All counters 0.
  - trig synchronizer flops = 1, so a trig already high at reset release is not taken as a rising edge.
- Synchronization: trig passes a 2-flop synchronizer. An edge is detected on the synchronized value against its registered copy. Synchronizer latency is 2 clk and is not counted in tick widths.
- State machine: IDLE, TRIG, BURST, ECHO, HOLDOFF.
- IDLE:
  - On a synchronized trig rising edge: trig_cnt=0, go TRIG.
- TRIG:
  - On i_tick with trig high: trig_cnt+1, saturating at 8'hFF.
  - On a synchronized trig falling edge:
    - If trig_cnt >= TRIG_MIN_US: latch i_distance and compute echo_len (16 bit).
      - echo_len = i_distance*US_PER_CM if 1 <= i_distance <= MAX_CM.
      - echo_len = TIMEOUT_US otherwise.
      - cnt=0, go BURST.
    - Else: trig_err=1 for one clk, go IDLE.
  - A falling edge coinciding with i_tick: increment first, then compare.
- BURST:
  - cnt+1 on each i_tick.
  - On the tick where cnt+1 == BURST_DELAY_US: echo=1 on the next edge, cnt=0, go ECHO.
- ECHO:
  - echo held high. cnt+1 on each i_tick.
  - On the tick where cnt+1 == echo_len: echo=0, cnt=0, go HOLDOFF.
  - Echo is therefore high across exactly echo_len i_tick strobes.
- HOLDOFF:
  - cnt+1 on each i_tick; on the tick where cnt+1 == HOLDOFF_US, go IDLE.
  - trig is ignored here.
  - A trig still high on entering IDLE is not accepted until it goes low and rises again.
- Triggers during BURST, ECHO and HOLDOFF are ignored and do not set trig_err.
- i_distance changes after the latch do not affect the echo in progress.
- Widths:
  - echo_len and cnt are 16 bit.
  - Product is computed at 16 bit; valid range max 400*58 = 23200, no overflow.
  - Out-of-range inputs never reach the multiply result path.
- Mid-operation reset: echo drops immediately (async) and the FSM returns to IDLE. No trig_err.

Test Plan:
1. i_distance=10, 12-tick trig -> echo rises 200 ticks after trig fall; high for 580 ticks; distance_calculator reads 10; busy high from trig rise to HOLDOFF end.
2. 5-tick trig pulse -> trig_err one clk pulse after trig fall; echo stays 0; state back to IDLE.
3. i_distance=0, then i_distance=500, each with a valid trig -> echo width 38000 ticks both times.
4. i_distance=400 -> echo 23200 ticks; change i_distance to 5 mid-echo -> width unchanged.
5. Second trig during ECHO and again during HOLDOFF -> ignored, no trig_err. Trig after HOLDOFF (1000 ticks) -> new echo produced.
6. Assert rst low mid-ECHO with trig held high through release -> echo=0 asynchronously; no echo until trig falls and rises again with a valid width.

Source files
------------

// File: rtl/sr04_echo_responder.sv
// SR04 sensor-side responder: accepts a trigger pulse, waits the burst delay,
// then drives an echo pulse whose width (in 1 us ticks) encodes a distance.
module sr04_echo_responder #(
    parameter int TRIG_MIN_US    = 10,
    parameter int BURST_DELAY_US = 200,
    parameter int US_PER_CM      = 58,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_US     = 38000,
    parameter int HOLDOFF_US     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       trig,
    input  logic [9:0] i_distance,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_ECHO  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [7:0]  TRIG_MIN    = 8'(TRIG_MIN_US);
    localparam logic [15:0] BURST_LEN   = 16'(BURST_DELAY_US);
    localparam logic [15:0] HOLD_LEN    = 16'(HOLDOFF_US);
    localparam logic [15:0] TIMEOUT_LEN = 16'(TIMEOUT_US);
    localparam logic [15:0] UPC         = 16'(US_PER_CM);
    localparam logic [9:0]  MAX_D       = 10'(MAX_CM);

    logic        trig_s1;
    logic        trig_s2;
    logic        trig_q;
    logic        trig_rise;
    logic        trig_fall;
    logic [2:0]  state;
    logic [7:0]  trig_cnt;
    logic [7:0]  trig_cnt_inc;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [15:0] echo_len;
    logic [15:0] mult_in;
    logic [15:0] len_calc;
    logic        dist_ok;

    // Two-flop synchronizer plus edge-detect copy; preset high so a trig
    // already asserted at reset release does not look like a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_s1 <= 1'b1;
            trig_s2 <= 1'b1;
            trig_q  <= 1'b1;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_q  <= trig_s2;
        end
    end

    assign trig_rise = trig_s2 & ~trig_q;
    assign trig_fall = ~trig_s2 & trig_q;
    assign busy      = (state != S_IDLE);
    assign cnt_inc   = cnt + 16'd1;

    // Saturating trigger-width count; a tick coinciding with the falling
    // edge still counts so the compare sees the incremented value.
    always_comb begin
        trig_cnt_inc = trig_cnt;
        if (i_tick && (trig_s2 || trig_fall) && (trig_cnt != 8'hFF))
            trig_cnt_inc = trig_cnt + 8'd1;
    end

    // Echo length: out-of-range distances are gated off the multiplier and
    // replaced by the timeout width.
    always_comb begin
        dist_ok  = (i_distance != 10'd0) && (i_distance <= MAX_D);
        mult_in  = dist_ok ? {6'd0, i_distance} : 16'd0;
        len_calc = dist_ok ? (mult_in * UPC) : TIMEOUT_LEN;
    end

    // Main protocol FSM: trigger qualification, burst delay, echo, holdoff.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            trig_cnt <= 8'd0;
            cnt      <= 16'd0;
            echo_len <= 16'd0;
            echo     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            trig_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        trig_cnt <= 8'd0;
                        state    <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    trig_cnt <= trig_cnt_inc;
                    if (trig_fall) begin
                        if (trig_cnt_inc >= TRIG_MIN) begin
                            echo_len <= len_calc;
                            cnt      <= 16'd0;
                            state    <= S_BURST;
                        end else begin
                            trig_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_BURST: begin
                    if (i_tick) begin
                        if (cnt_inc == BURST_LEN) begin
                            echo  <= 1'b1;
                            cnt   <= 16'd0;
                            state <= S_ECHO;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_ECHO: begin
                    if (i_tick) begin
                        if (cnt_inc == echo_len) begin
                            echo  <= 1'b0;
                            cnt   <= 16'd0;
                            state <= S_HOLD;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_tick) begin
                        if (cnt_inc == HOLD_LEN) begin
                            cnt   <= 16'd0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    echo  <= 1'b0;
                    cnt   <= 16'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_echo_responder.sv
// Bench for sr04_echo_responder with shortened timing parameters.
module tb_sr04_echo_responder;

    localparam int TMIN  = 10;
    localparam int BURST = 20;
    localparam int UPC   = 3;
    localparam int MAXC  = 400;
    localparam int TMO   = 1500;
    localparam int HOLD  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_tick = 1'b0;
    logic       trig = 1'b0;
    logic [9:0] i_distance = 10'd0;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int ecnt = 0;
    int hcnt = 0;
    bit e_prev = 1'b0;
    bit in_hold = 1'b0;
    logic [15:0] exp_q[$];

    sr04_echo_responder #(
        .TRIG_MIN_US(TMIN), .BURST_DELAY_US(BURST), .US_PER_CM(UPC),
        .MAX_CM(MAXC), .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .trig(trig),
        .i_distance(i_distance), .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    // 1 us strobe: high one clock out of every two
    initial forever begin
        @(negedge clk);
        i_tick = ~i_tick;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_len(input int d);
        if (d >= 1 && d <= MAXC) return 16'(d * UPC);
        return 16'(TMO);
    endfunction

    // Output monitor: echo width and holdoff length in ticks, trig_err pulses
    always @(negedge clk) begin
        if (!rst) begin
            ecnt = 0; hcnt = 0; e_prev = 1'b0; in_hold = 1'b0;
        end else begin
            if (trig_err) err_cnt++;
            if (echo && i_tick) ecnt++;
            if (!echo && e_prev) begin
                if (exp_q.size() == 0) chk("echo_unexpected", 1, 0);
                else chk("echo_width", ecnt, exp_q.pop_front());
                ecnt = 0; hcnt = 0; in_hold = 1'b1;
            end
            if (in_hold) begin
                if (busy) begin
                    if (i_tick) hcnt++;
                end else begin
                    chk("holdoff_ticks", hcnt, HOLD);
                    in_hold = 1'b0;
                end
            end
            e_prev = echo;
        end
    end

    // Drive one trigger of n ticks; for an accepted one measure the burst
    // delay and return at echo rise, otherwise expect a single trig_err.
    task automatic fire(input int d, input int n, input bit ok, input bit push);
        int c;
        int e0;
        bit done;
        @(negedge clk);
        i_distance = 10'(d);
        trig = 1'b1;
        if (push) exp_q.push_back(model_len(d));
        repeat (4) @(negedge clk);
        chk("busy_trig", busy, 1);
        repeat (2 * n - 4) @(negedge clk);
        trig = 1'b0;
        e0 = err_cnt;
        if (ok) begin
            repeat (3) @(posedge clk);
            c = 0; done = 1'b0;
            for (int i = 0; i < 8 * BURST && !done; i++) begin
                @(negedge clk);
                if (echo) done = 1'b1;
                else if (i_tick) c++;
            end
            chk("burst_ticks", c, BURST);
            chk("no_err", err_cnt - e0, 0);
        end else begin
            repeat (10) @(negedge clk);
            chk("err_pulse", err_cnt - e0, 1);
            chk("err_echo", echo, 0);
            chk("err_idle", busy, 0);
        end
    endtask

    task automatic raw_pulse(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (2 * n) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4 * (TMO + HOLD + BURST) && busy; i++) @(negedge clk);
        @(negedge clk);
        chk(tag, busy, 0);
    endtask

    task automatic wait_echo_fall();
        for (int i = 0; i < 4 * TMO && echo; i++) @(negedge clk);
        chk("echo_fell", echo, 0);
    endtask

    initial begin
        int e0;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_echo", echo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", trig_err, 0);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // basic measurement
        fire(10, 12, 1, 1);
        wait_idle("idle_t1");

        // short triggers rejected, minimum width accepted
        fire(1, 5, 0, 0);
        fire(1, TMIN - 1, 0, 0);
        fire(1, TMIN, 1, 1);
        wait_idle("idle_t2");

        // zero and out-of-range distances give the timeout width
        fire(0, 12, 1, 1);
        wait_idle("idle_t3a");
        fire(500, 12, 1, 1);
        wait_idle("idle_t3b");
        fire(MAXC + 1, 12, 1, 1);
        wait_idle("idle_t3c");

        // maximum distance; distance change mid-echo has no effect
        fire(MAXC, 12, 1, 1);
        repeat (200) @(negedge clk);
        i_distance = 10'd5;
        wait_idle("idle_t4");

        // triggers during echo and holdoff are ignored
        e0 = err_cnt;
        fire(20, 12, 1, 1);
        raw_pulse(12);
        wait_echo_fall();
        repeat (4) @(negedge clk);
        raw_pulse(12);
        wait_idle("idle_t5");
        chk("ignored_err", err_cnt - e0, 0);
        fire(7, 12, 1, 1);
        wait_idle("idle_t5b");

        // reset mid-echo with trig held high through release
        fire(100, 12, 1, 0);
        repeat (40) @(negedge clk);
        trig = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_echo", echo, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("held_trig_echo", echo, 0);
        chk("held_trig_busy", busy, 0);
        trig = 1'b0;
        repeat (6) @(negedge clk);
        chk("trig_low_busy", busy, 0);
        fire(50, 12, 1, 1);
        wait_idle("idle_t6");

        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
